// File: rtl/fetch_queue.sv
// Instruction fetch engine feeding a DEPTH-entry in-order buffer toward decode.
// Latency: first deq_valid two cycles after reset release or redirect; one instruction per cycle at steady state.
// Backpressure: fetch issue stalls when buffered + in-flight words would reach DEPTH; redirect flushes everything.
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     stop,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [31:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   occ_t;

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  localparam occ_t        DEPTH_OCC = occ_t'(DEPTH);
  localparam logic [32:0] IMEM_LIM  = 33'(IMEM_BYTES);

  state_t      state;
  state_t      state_nxt;
  logic        inflight;
  logic [31:0] req_pc;
  ptr_t        head;
  ptr_t        tail;
  cnt_t        cnt;

  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];

  logic pc_oob;
  logic room;
  logic issue;
  logic enq;
  logic deq;

  // Issue only while there is guaranteed space for the word coming back,
  // counting the one already in flight, so the buffer can never overflow.
  assign pc_oob = ({1'b0, pc} >= IMEM_LIM);
  assign room   = (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < DEPTH_OCC);
  assign issue  = (state == FETCH) && !redirect && !pc_oob && room;
  assign enq    = inflight && !stop && !redirect;
  assign deq    = deq_valid && deq_ready;

  assign count     = cnt;
  assign deq_valid = (cnt != '0) && !redirect;
  assign deq_instr = (cnt != '0) ? buf_instr[head] : 32'h0;
  assign deq_pc    = (cnt != '0) ? buf_pc[head]    : 32'h0;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: redirect always restarts fetch; end marker or running off memory halts
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else if (state == FETCH && ((inflight && stop) || pc_oob)) begin
      state_nxt = HALT;
    end
  end

  // State-derived outputs
  always_comb begin
    halted = 1'b0;
    if (state == HALT) begin
      halted = 1'b1;
    end
  end

  // Fetch address, in-flight tracking and buffer bookkeeping; redirect wins over everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      req_pc   <= 32'h0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are masked at the outputs while empty, so no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_instr[tail] <= instr;
      buf_pc[tail]    <= req_pc;
    end
  end

endmodule
